// File: rtl/spi_regfile_peripheral_pkg.sv
// ----------------------------------------------------------------------------
// spi_regfile_peripheral_pkg
//   Shared definitions for the SPI register-file peripheral: FSM state type,
//   R/W bit meaning and the frame-length helper.
// ----------------------------------------------------------------------------
package spi_regfile_peripheral_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    // Value of the leading frame bit that marks a write.
    localparam logic RW_WRITE = 1'b1;

    // Frame = R/W bit + address field + data field.
    function automatic int unsigned frame_width(input int unsigned addr_w,
                                                input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
//   Multi-stage synchroniser for one asynchronous input, plus rise/fall
//   detection of the synchronised level against one extra flip-flop.
// Ports
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   d     in   asynchronous input
//   q     out  synchronised level (last synchroniser stage)
//   rise  out  one-cycle strobe, q went 0->1
//   fall  out  one-cycle strobe, q went 1->0
// ----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              last;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            last  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            last  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~last;
    assign fall = ~q & last;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// ----------------------------------------------------------------------------
// spi_regfile_peripheral
//   SPI mode-0 peripheral with a retained register file, fully synchronous to
//   clk. sclk/cs_n/copi are oversampled; fixed-length frames
//   {R/W, address, data} (MSB first) write a register or read one back on cipo.
// Ports
//   clk        in   system clock, sole clock domain
//   rst        in   synchronous active-high reset
//   sclk       in   SPI clock (asynchronous)
//   cs_n       in   SPI chip select, active-low (asynchronous)
//   copi       in   controller-out peripheral-in (asynchronous)
//   cipo       out  controller-in peripheral-out (0 when not driving)
//   cipo_oe    out  pad output enable for cipo
//   reg_q      out  register file, reg n at [n*DATA_W +: DATA_W]
//   wr_pulse   out  one-cycle strobe, a register was written
//   wr_addr    out  address of the last write, valid with wr_pulse
//   frame_err  out  one-cycle strobe, frame rejected
// ----------------------------------------------------------------------------
module spi_regfile_peripheral
    import spi_regfile_peripheral_pkg::*;
#(
    parameter int unsigned       NUM_REGS    = 5,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 7,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter int unsigned       READ_EN     = 1,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int unsigned      FRAME_W  = frame_width(ADDR_W, DATA_W);
    localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    // bit_cnt value just before / just after the last address bit is captured
    localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_ADDR_DONE = CNT_W'(ADDR_W + 1);
    localparam logic [ADDR_W:0]  NUM_REGS_L    = (ADDR_W + 1)'(NUM_REGS);

    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic copi_q, copi_rise, copi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );
    // cs_n resets high so leaving reset never looks like a frame start.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d(copi), .q(copi_q), .rise(copi_rise), .fall(copi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_q, cs_fall, copi_rise, copi_fall};

    state_t              state, state_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  rx_shift;
    logic                overrun;
    logic [DATA_W-1:0]   tx_shift;
    logic                oe;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    // Address as it stands once the incoming copi bit is appended; used on the
    // sclk rise that completes the address field.
    logic [ADDR_W-1:0]   addr_early;
    logic                rw_early;
    logic [DATA_W-1:0]   rd_data;

    assign addr_early = ADDR_W'({rx_shift, copi_q});
    assign rw_early   = rx_shift[ADDR_W-1];

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ADDR_W'(i) == addr_early) rd_data = regs[i];
        end
    end

    logic                rw_bit;
    logic [ADDR_W-1:0]   fr_addr;
    logic [DATA_W-1:0]   fr_data;
    logic                full_len, do_write, do_err, read_ok;

    assign rw_bit   = rx_shift[FRAME_W-1];
    assign fr_addr  = rx_shift[FRAME_W-2 -: ADDR_W];
    assign fr_data  = rx_shift[DATA_W-1:0];
    assign full_len = (bit_cnt == CNT_FULL) && !overrun;
    assign read_ok  = full_len && (rw_bit != RW_WRITE) && (READ_EN != 0);
    assign do_write = (state == ST_COMMIT) && full_len && (rw_bit == RW_WRITE)
                      && ({1'b0, fr_addr} < NUM_REGS_L);
    assign do_err   = (state == ST_COMMIT) && !do_write && !read_ok;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (!cs_q)   state_next = ST_SHIFT;
            ST_SHIFT:  if (cs_rise) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            overrun   <= 1'b0;
            tx_shift  <= '0;
            oe        <= 1'b0;
            wr_pulse  <= 1'b0;
            wr_addr   <= '0;
            frame_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                    overrun  <= 1'b0;
                    tx_shift <= '0;
                    oe       <= 1'b0;
                end
                ST_SHIFT: begin
                    // cs_n rise wins over any sclk edge seen in the same cycle.
                    if (cs_rise) begin
                        oe <= 1'b0;
                    end else if (sclk_rise) begin
                        if (bit_cnt != CNT_FULL) begin
                            rx_shift <= {rx_shift[FRAME_W-2:0], copi_q};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if ((READ_EN != 0) && (bit_cnt == CNT_ADDR_LAST)
                                && (rw_early != RW_WRITE)) begin
                                tx_shift <= rd_data;
                                oe       <= 1'b1;
                            end
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (sclk_fall && oe && (bit_cnt > CNT_ADDR_DONE)) begin
                        // The fall right after the load keeps the MSB on cipo so the
                        // controller samples it on the first data-phase rise.
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                ST_COMMIT: begin
                    if (do_write) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (ADDR_W'(i) == fr_addr) regs[i] <= fr_data;
                        end
                        wr_pulse <= 1'b1;
                        wr_addr  <= fr_addr;
                    end
                    if (do_err) frame_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs[i];
    end

    assign cipo_oe = oe;
    assign cipo    = oe & tx_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// ----------------------------------------------------------------------------
// tb_spi_regfile_peripheral
//   Drives SPI mode-0 frames at the pins and compares against a register-array
//   model of the peripheral: writes, reads, short/long/out-of-range frames,
//   reset mid-frame, back-to-back frames and randomized traffic.
// ----------------------------------------------------------------------------
module tb_spi_regfile_peripheral;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int SYNC     = 2;
    localparam int H        = 6;   // sclk half period in clk cycles

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       sclk;
    logic                       cs_n;
    logic                       copi;
    logic                       cipo;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] reg_q;
    logic                       wr_pulse;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    spi_regfile_peripheral #(
        .NUM_REGS(NUM_REGS),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .SYNC_STAGES(SYNC),
        .READ_EN(1),
        .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .cs_n(cs_n),
        .copi(copi),
        .cipo(cipo),
        .cipo_oe(cipo_oe),
        .reg_q(reg_q),
        .wr_pulse(wr_pulse),
        .wr_addr(wr_addr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0] model [NUM_REGS];

    function automatic logic [39:0] model_vec();
        logic [39:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    // Strobe counters, sampled away from the active edge.
    int         wr_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] last_wr_addr = '0;

    always @(negedge clk) begin
        if (wr_pulse) begin
            wr_cnt++;
            last_wr_addr = wr_addr;
        end
        if (frame_err) err_cnt++;
    end

    logic [7:0] rd_byte;
    logic [7:0] oe_byte;

    task automatic shift_bit(input logic b, input int idx);
        copi = b;
        repeat (H) @(negedge clk);
        sclk = 1'b1;
        if (idx >= 9 && idx <= 16) begin
            rd_byte = {rd_byte[6:0], cipo};
            oe_byte = {oe_byte[6:0], cipo_oe};
        end
        repeat (H) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [31:0] val);
        cs_n    = 1'b0;
        rd_byte = '0;
        oe_byte = '0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < n; i++) shift_bit(val[n-1-i], i + 1);
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int n, input logic [31:0] val);
        int         w0, e0, first;
        logic       rw;
        logic [6:0] a;
        logic [7:0] d;
        bit         exp_wr, exp_err;
        w0    = wr_cnt;
        e0    = err_cnt;
        first = 0;
        rw    = (n == 16) ? val[15] : 1'b0;
        a     = val[14:8];
        d     = val[7:0];
        exp_wr  = (n == 16) && rw && (a < NUM_REGS);
        exp_err = !((n == 16) && (exp_wr || !rw));
        send_bits(n, val);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ((wr_pulse || frame_err) && first == 0) first = k;
        end
        if (n == 16 && !rw) begin
            check({tag, "/rdata"}, 64'(rd_byte), 64'(model[a]));
            check({tag, "/rd_oe"}, 64'(oe_byte), 64'hFF);
        end
        if (exp_wr) model[a] = d;
        check({tag, "/wr_cnt"}, 64'(wr_cnt - w0), 64'(exp_wr));
        check({tag, "/err_cnt"}, 64'(err_cnt - e0), 64'(exp_err));
        if (exp_wr || exp_err) check({tag, "/latency"}, 64'(first), 64'(SYNC + 2));
        if (exp_wr) check({tag, "/wr_addr"}, 64'(last_wr_addr), 64'(a));
        check({tag, "/reg_q"}, 64'(reg_q), 64'(model_vec()));
        check({tag, "/oe_idle"}, 64'({cipo_oe, cipo}), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         w0, e0, n, r;
        logic       rw;
        logic [6:0] a;
        logic [7:0] d;
        logic [31:0] val;

        rst  = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        copi = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        check("rst/reg_q", 64'(reg_q), 64'(model_vec()));
        check("rst/outs", 64'({cipo, cipo_oe, wr_pulse, frame_err}), 64'(0));
        check("rst/wr_addr", 64'(wr_addr), 64'(0));
        check("rst/no_strobe", 64'(wr_cnt + err_cnt), 64'(0));

        // write, out-of-range write, short and overrun frames
        run_frame("t1_wr0", 16, 32'h80F0);
        run_frame("t2_wr4", 16, 32'h843C);
        run_frame("t2_wr5", 16, 32'h85FF);
        run_frame("t3_short", 12, 32'h815);
        run_frame("t3_long", 17, 32'h102AB);

        // write then read back
        run_frame("t4_wr2", 16, 32'h82A5);
        run_frame("t4_rd2", 16, 32'h0200);

        // reset mid-frame aborts silently
        w0 = wr_cnt;
        e0 = err_cnt;
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        val = 32'h8177;
        for (int i = 0; i < 9; i++) shift_bit(val[15-i], i + 1);
        @(negedge clk);
        rst  = 1'b1;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        check("t5/reg_q", 64'(reg_q), 64'(model_vec()));
        check("t5/no_strobe", 64'((wr_cnt - w0) + (err_cnt - e0)), 64'(0));
        run_frame("t5_after", 16, 32'h8166);

        // back-to-back frames with cs_n high for SYNC+3 cycles
        w0 = wr_cnt;
        e0 = err_cnt;
        send_bits(16, 32'h8012);
        repeat (SYNC + 3) @(negedge clk);
        send_bits(16, 32'h8334);
        repeat (12) @(negedge clk);
        model[0] = 8'h12;
        model[3] = 8'h34;
        check("t6/wr_cnt", 64'(wr_cnt - w0), 64'(2));
        check("t6/err_cnt", 64'(err_cnt - e0), 64'(0));
        check("t6/reg_q", 64'(reg_q), 64'(model_vec()));

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       n = 16;
            else if (r == 7) n = int'($urandom_range(10, 15));
            else             n = int'($urandom_range(17, 18));
            rw = ($urandom_range(0, 2) != 0);
            a  = rw ? 7'($urandom_range(0, 6)) : 7'($urandom_range(0, 4));
            d  = 8'($urandom);
            if (n == 16) val = {16'h0, rw, a, d};
            else         val = $urandom;
            run_frame("rand", n, val);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
